// File: rtl/fp_unpacker_if.sv
// ----------------------------------------------------------------------------
// fp_unpacker_if
// Handshake and result bundle for fp_unpacker.
//   in_valid/in_ready/op/db     : operand channel (producer -> unpacker)
//   out_valid/out_ready         : result channel handshake
//   s/e/f                       : unpacked sign, signed exponent, significand
//   zero/denorm/inf/nan/snan    : class flags of the accepted operand
// Modports: master = operand producer / result consumer, slave = unpacker.
// ----------------------------------------------------------------------------
interface fp_unpacker_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op;
    logic        db;
    logic        out_valid;
    logic        out_ready;
    logic        s;
    logic [12:0] e;
    logic [52:0] f;
    logic        zero;
    logic        denorm;
    logic        inf;
    logic        nan;
    logic        snan;

    modport master (
        output in_valid, op, db, out_ready,
        input  in_ready, out_valid, s, e, f, zero, denorm, inf, nan, snan
    );

    modport slave (
        input  in_valid, op, db, out_ready,
        output in_ready, out_valid, s, e, f, zero, denorm, inf, nan, snan
    );
endinterface

// File: rtl/fp_unpacker.sv
// ----------------------------------------------------------------------------
// fp_unpacker
// Unpacks an IEEE-754 double (db=1) or single (db=0) operand into sign,
// signed 13-bit exponent (native bias) and a 53-bit significand with the
// hidden bit at f[52]. Denormals are normalised over several cycles in the
// NORM state; all other classes complete with latency 1.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fp_unpacker_if.slave (operand and result handshakes, outputs)
// Configuration:
//   UNPACK_FASTNORM_EN : when defined, NORM shifts by 8 while f[52:45] is
//                        zero, otherwise by 1. Final results are identical.
// ----------------------------------------------------------------------------
module fp_unpacker (
    input logic          clk,
    input logic          rst_n,
    fp_unpacker_if.slave bus
);

    typedef enum logic {StIdle, StNorm} state_e;

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic        s_q, s_d;
    logic [12:0] e_q, e_d;
    logic [52:0] f_q, f_d;
    logic [4:0]  flags_q, flags_d;  // {zero, denorm, inf, nan, snan}

    logic        accept;
    logic [10:0] exp_raw;
    logic [10:0] emax;
    logic [51:0] frac_raw;          // fraction left-aligned to f[51:0]
    logic        exp_zero;
    logic        exp_max;
    logic        frac_zero;
    logic [3:0]  norm_shift;
    logic [52:0] f_shifted;

    assign bus.in_ready  = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.e         = e_q;
    assign bus.f         = f_q;
    assign bus.zero      = flags_q[4];
    assign bus.denorm    = flags_q[3];
    assign bus.inf       = flags_q[2];
    assign bus.nan       = flags_q[1];
    assign bus.snan      = flags_q[0];

    // Field extraction for both formats; single fraction lands at f[51:29].
    always_comb begin
        exp_raw  = '0;
        emax     = '0;
        frac_raw = '0;
        if (bus.db) begin
            exp_raw  = bus.op[62:52];
            frac_raw = bus.op[51:0];
            emax     = 11'h7FF;
        end else begin
            exp_raw  = {3'b000, bus.op[62:55]};
            frac_raw = {bus.op[54:32], 29'd0};
            emax     = 11'h0FF;
        end
    end

    assign exp_zero  = (exp_raw == 11'd0);
    assign exp_max   = (exp_raw == emax);
    assign frac_zero = (frac_raw == 52'd0);

    // Normalisation step size.
    always_comb begin
        norm_shift = 4'd1;
`ifdef UNPACK_FASTNORM_EN
        // With the top 8 bits clear the leading one sits at or below bit 44,
        // so an 8-bit step can never overshoot the hidden-bit position.
        if (f_q[52:45] == 8'd0) begin
            norm_shift = 4'd8;
        end
`else
        norm_shift = 4'd1;
`endif
        f_shifted = f_q << norm_shift;
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        e_d         = e_q;
        f_d         = f_q;
        flags_d     = flags_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    s_d         = bus.op[63];
                    flags_d     = 5'b00000;
                    out_valid_d = 1'b1;
                    if (exp_zero) begin
                        if (frac_zero) begin
                            e_d        = 13'd0;
                            f_d        = 53'd0;
                            flags_d[4] = 1'b1;
                        end else begin
                            // Denormal: normalise in StNorm, no result yet.
                            e_d         = 13'd1;
                            f_d         = {1'b0, frac_raw};
                            flags_d[3]  = 1'b1;
                            out_valid_d = 1'b0;
                            state_d     = StNorm;
                        end
                    end else begin
                        // Normal, inf and NaN share the same e/f packing.
                        e_d = {2'b00, exp_raw};
                        f_d = {1'b1, frac_raw};
                        if (exp_max) begin
                            if (frac_zero) begin
                                flags_d[2] = 1'b1;
                            end else begin
                                flags_d[1] = 1'b1;
                                flags_d[0] = ~frac_raw[51];
                            end
                        end
                    end
                end
            end
            StNorm: begin
                f_d = f_shifted;
                e_d = e_q - {9'd0, norm_shift};
                if (f_shifted[52]) begin
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            s_q         <= 1'b0;
            e_q         <= 13'd0;
            f_q         <= 53'd0;
            flags_q     <= 5'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            e_q         <= e_d;
            f_q         <= f_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_unpacker.sv
// ----------------------------------------------------------------------------
// tb_fp_unpacker
// Directed self-checking bench for fp_unpacker. Define UNPACK_FASTNORM_EN to
// match a DUT built with the fast normalisation step.
// ----------------------------------------------------------------------------
module tb_fp_unpacker;

`ifdef UNPACK_FASTNORM_EN
    localparam int DenLat = 10;
`else
    localparam int DenLat = 52;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fp_unpacker_if bus ();

    fp_unpacker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus.zero, bus.denorm, bus.inf, bus.nan, bus.snan};
    endfunction

    // Offer one operand, measure edges from accept until out_valid, then
    // compare the result. exp_lat 0 means out_valid right after the accept.
    task automatic run(input string tag, input logic [63:0] op_v, input logic db_v,
                       input int exp_lat, input logic s_x, input logic [12:0] e_x,
                       input logic [52:0] f_x, input logic [4:0] fl_x);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op_v;
        bus.db       = db_v;
        check({tag, "_rdy"}, {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_s"}, {63'd0, bus.s}, {63'd0, s_x});
        check({tag, "_e"}, {51'd0, bus.e}, {51'd0, e_x});
        check({tag, "_f"}, {11'd0, bus.f}, {11'd0, f_x});
        check({tag, "_flags"}, {59'd0, flags()}, {59'd0, fl_x});
    endtask

    initial begin
        bit seen;
        n_checks      = 0;
        n_errors      = 0;
        bus.in_valid  = 1'b0;
        bus.op        = 64'd0;
        bus.db        = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ov", {63'd0, bus.out_valid}, 64'd0);
        check("rst_e", {51'd0, bus.e}, 64'd0);
        check("rst_f", {11'd0, bus.f}, 64'd0);
        check("rst_flags", {59'd0, flags()}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rdy", {63'd0, bus.in_ready}, 64'd1);

        // Flags order: {zero, denorm, inf, nan, snan}
        run("one_d", 64'h3FF0000000000000, 1'b1, 0, 1'b0, 13'h03FF,
            53'h10000000000000, 5'b00000);
        // Back-to-back: previous result handshaken on the same edge.
        run("m2p5_s", 64'hC0200000_00000000, 1'b0, 0, 1'b1, 13'h0080,
            53'h14000000000000, 5'b00000);
        run("nzero_d", 64'h8000000000000000, 1'b1, 0, 1'b1, 13'h0000,
            53'h0, 5'b10000);
        run("inf_d", 64'h7FF0000000000000, 1'b1, 0, 1'b0, 13'h07FF,
            53'h10000000000000, 5'b00100);
        run("qnan_d", 64'h7FF8000000000000, 1'b1, 0, 1'b0, 13'h07FF,
            53'h18000000000000, 5'b00010);
        run("snan_s", 64'h7F800001_00000000, 1'b0, 0, 1'b0, 13'h00FF,
            53'h10000020000000, 5'b00011);
        run("den_d", 64'h0000000000000001, 1'b1, DenLat, 1'b0, 13'h1FCD,
            53'h10000000000000, 5'b01000);
        run("den_s", 64'h00400000_00000000, 1'b0, 1, 1'b0, 13'h0000,
            53'h10000000000000, 5'b01000);

        @(posedge clk);
        #1;
        check("ov_clr", {63'd0, bus.out_valid}, 64'd0);

        // Stall: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        run("stall", 64'h3FF0000000000000, 1'b1, 0, 1'b0, 13'h03FF,
            53'h10000000000000, 5'b00000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rdy", {63'd0, bus.in_ready}, 64'd0);
            check("stall_ov", {63'd0, bus.out_valid}, 64'd1);
            check("stall_e", {51'd0, bus.e}, 64'h03FF);
            check("stall_f", {11'd0, bus.f}, 64'h10000000000000);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check("stall_rel_rdy", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        check("stall_rel_ov", {63'd0, bus.out_valid}, 64'd0);

        // Reset in the middle of normalisation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 64'h0000000000000001;
        bus.db       = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_busy", {63'd0, bus.in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_e", {51'd0, bus.e}, 64'd0);
        check("mid_rst_f", {11'd0, bus.f}, 64'd0);
        check("mid_rst_flags", {59'd0, flags()}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("mid_no_ov", {63'd0, seen}, 64'd0);
        run("post_rst", 64'h3FF0000000000000, 1'b1, 0, 1'b0, 13'h03FF,
            53'h10000000000000, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_unpacker.md
FP_UNPACKER -- requirements
Module: fp_unpacker

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  operand offered.
REQ-004 in_ready  output  1  operand accepted when in_valid & in_ready at a clk edge.
REQ-005 op  input  64  packed operand; db=1: s=op[63], e=op[62:52], frac=op[51:0]; db=0: s=op[63], e=op[62:55], frac=op[54:32], op[31:0] ignored.
REQ-006 db  input  1  1=double, 0=single; sampled with op.
REQ-007 out_valid  output  1  unpacked result available.
REQ-008 out_ready  input  1  consumer takes result when out_valid & out_ready.
REQ-009 s  output  1  sign.
REQ-010 e  output  13  signed two's-complement exponent, native bias (1023 double, 255 single).
REQ-011 f  output  53  significand, hidden bit at f[52]; single fraction at f[51:29], f[28:0]=0.
REQ-012 zero, denorm, inf, nan, snan  output  1 each  class flags of accepted operand.

Function
REQ-013 States SHALL be IDLE and NORM; in_ready=1 only in IDLE with (~out_valid | out_ready).
REQ-014 Accept of normal (0<e<emax): s, e zero-extended, f={1,frac}, out_valid=1 the next cycle (latency 1).
REQ-015 Zero (e=0, frac=0): e=0, f=0, zero=1, latency 1.
REQ-016 Inf (e=emax, frac=0): e=emax, f={1,0...}, inf=1, latency 1.
REQ-017 NaN (e=emax, frac!=0): e=emax, f={1,frac}, nan=1, snan=~frac msb, latency 1.
REQ-018 Denormal (e=0, frac!=0): load e=1, f={0,frac}, denorm=1, enter NORM, out_valid stays 0.
REQ-019 NORM: each cycle f<<=1, e-=1; on the cycle the shifted f[52]=1, set out_valid=1, return to IDLE; latency = leading-zero count lz of {0,frac}.
REQ-020 Result SHALL be e=1-lz (e.g. -51 minimum for double), no saturation.
REQ-021 While out_valid & ~out_ready, all outputs SHALL hold stable.
REQ-022 out_valid clears on out_ready handshake unless a new operand is accepted the same edge (back-to-back, normal class: out_valid stays 1 with new data).
REQ-023 emax=2047 (db=1) or 255 (db=0).

Reset
REQ-024 rst_n low SHALL immediately force IDLE, out_valid=0, s=0, e=0, f=0, all flags 0; in_ready=1 after release.
REQ-025 Reset during NORM SHALL abandon the operation with no out_valid pulse.

Configuration
REQ-026 Macro UNPACK_FASTNORM_EN defined: in NORM, if f[52:45]==0 shift by 8 and e-=8, else shift by 1 and e-=1; undefined: always shift by 1 (REQ-019); final e and f identical either way.

Verification
REQ-027 op=64'h3FF0000000000000, db=1 -> one cycle later out_valid=1, s=0, e=13'h03FF, f=53'h10000000000000, flags 0.
REQ-028 op=64'h0000000000000001, db=1 -> denorm=1, e=13'h1FCD (-51), f=53'h10000000000000; out_valid after 52 cycles, 10 cycles with UNPACK_FASTNORM_EN.
REQ-029 op=64'h7F800001_00000000, db=0 -> nan=1, snan=1, e=13'h00FF, f={1,23'h000001,29'b0}.
REQ-030 out_ready=0 for 5 cycles after a result -> in_ready=0, outputs unchanged; out_ready=1 -> handshake, in_ready=1.
REQ-031 rst_n pulsed low mid-NORM on REQ-028 operand -> outputs zero immediately, no out_valid, next 1.0 operand unpacks per REQ-027.
